// File: rtl/usb_crc_pkg.sv
// ============================================================================
// Module   : usb_crc_pkg
// Purpose  : Shared USB CRC polynomials, good-packet residuals and FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package usb_crc_pkg;

    localparam logic [15:0] POLY16     = 16'h8005;
    localparam logic [4:0]  POLY5      = 5'h05;
    localparam logic [15:0] RESIDUAL16 = 16'h800D;
    localparam logic [4:0]  RESIDUAL5  = 5'h0C;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } crc_state_t;

endpackage

`default_nettype wire

// File: rtl/usb_crc_lfsr.sv
// ============================================================================
// Module   : usb_crc_lfsr
// Purpose  : Serial CRC shift register; feedback enabled while accumulating,
//            plain zero-fill shift while flushing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module usb_crc_lfsr
    import usb_crc_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = POLY16[CRC_W-1:0]
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load_ones,
    input  logic             shift,
    input  logic             fb_en,
    input  logic             data_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] r_crc;
    logic             w_fb;
    logic [CRC_W-1:0] w_crc_nxt;

    assign w_fb      = fb_en & (r_crc[CRC_W-1] ^ data_in);
    assign w_crc_nxt = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : {CRC_W{1'b0}});

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_crc <= '1;
        end else if (load_ones) begin
            r_crc <= '1;
        end else if (shift) begin
            r_crc <= w_crc_nxt;
        end
    end

    assign crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/usb_crc_engine.sv
// ============================================================================
// Module   : usb_crc_engine
// Purpose  : USB CRC5/CRC16 generator/checker with serial CRC flush, check
//            strobe and optional saturating error counter (USB_CRC_ERRCNT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module usb_crc_engine
    import usb_crc_pkg::*;
#(
    parameter int          CRC_W    = 16,
    parameter logic [15:0] POLY     = 16'h8005,
    parameter logic [15:0] RESIDUAL = 16'h800D
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       shift_enable,
    input  logic       d_orig,
    input  logic       flush_start,
    input  logic       check,
    output logic       crc_ok,
    output logic       crc_out_bit,
    output logic       crc_out_valid,
    output logic       crc_done,
    output logic       crc_err,
    output logic [7:0] err_cnt
);

    localparam int               CNT_W      = $clog2(CRC_W);
    localparam logic [CRC_W-1:0] c_POLY     = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] c_RESIDUAL = RESIDUAL[CRC_W-1:0];
    localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(CRC_W - 1);

    crc_state_t       r_state;
    crc_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_crc_err;
    logic             w_load_ones;
    logic             w_shift;
    logic             w_fb_en;
    logic             w_done;
    logic [CRC_W-1:0] w_crc;

    usb_crc_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (c_POLY)
    ) u_lfsr (
        .clk       (clk),
        .n_rst     (n_rst),
        .load_ones (w_load_ones),
        .shift     (w_shift),
        .fb_en     (w_fb_en),
        .data_in   (d_orig),
        .crc       (w_crc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The final flush shift reloads all-ones instead of shifting, ready for the next packet.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_ones = 1'b0;
        w_shift     = 1'b0;
        w_fb_en     = 1'b0;
        w_done      = 1'b0;
        if (clear) begin
            w_state_nxt = ACCUM;
            w_cnt_nxt   = '0;
            w_load_ones = 1'b1;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (flush_start) begin
                        w_state_nxt = FLUSH;
                        w_cnt_nxt   = '0;
                    end else if (shift_enable) begin
                        w_shift = 1'b1;
                        w_fb_en = 1'b1;
                    end
                end
                FLUSH: begin
                    if (shift_enable) begin
                        if (r_cnt == c_LAST) begin
                            w_done      = 1'b1;
                            w_load_ones = 1'b1;
                            w_state_nxt = ACCUM;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_shift   = 1'b1;
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ACCUM;
            endcase
        end
    end

    assign crc_ok        = (w_crc == c_RESIDUAL);
    assign crc_out_valid = (r_state == FLUSH);
    assign crc_out_bit   = crc_out_valid & ~w_crc[CRC_W-1];
    assign crc_done      = w_done;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_crc_err <= 1'b0;
        end else if (clear) begin
            r_crc_err <= 1'b0;
        end else if (check) begin
            r_crc_err <= ~crc_ok;
        end
    end

    assign crc_err = r_crc_err;

`ifdef USB_CRC_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Only reset clears the counter; clear merely suppresses a coincident check.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err_cnt <= '0;
        end else if (!clear && check && !crc_ok && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_crc_engine.sv
// ============================================================================
// Module   : tb_usb_crc_engine
// Purpose  : Scoreboard bench for usb_crc_engine (CRC_W=16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_usb_crc_engine;

    localparam logic [15:0] c_W0 = 16'b0000000010000000;
    localparam logic [15:0] c_W1 = 16'b0100000011000000;
    localparam logic [15:0] c_W2 = 16'b1111011101011110;
`ifdef USB_CRC_ERRCNT_EN
    localparam logic [7:0] c_CNT2 = 8'd2;
`else
    localparam logic [7:0] c_CNT2 = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       shift_enable;
    logic       d_orig;
    logic       flush_start;
    logic       check;
    logic       crc_ok;
    logic       crc_out_bit;
    logic       crc_out_valid;
    logic       crc_done;
    logic       crc_err;
    logic [7:0] err_cnt;

    typedef struct {
        logic bitv;
        logic done;
    } flush_exp_t;

    flush_exp_t q_flush[$];
    logic       q_err[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       pend_chk = 1'b0;

    usb_crc_engine u_dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .shift_enable  (shift_enable),
        .d_orig        (d_orig),
        .flush_start   (flush_start),
        .check         (check),
        .crc_ok        (crc_ok),
        .crc_out_bit   (crc_out_bit),
        .crc_out_valid (crc_out_valid),
        .crc_done      (crc_done),
        .crc_err       (crc_err),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sh, input logic d, input logic fl, input logic ck, input logic cl);
        shift_enable = sh;
        d_orig       = d;
        flush_start  = fl;
        check        = ck;
        clear        = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic feed16(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) drive(1'b1, w[i], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_check(input logic exp_err);
        q_err.push_back(exp_err);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_flush();
        logic [15:0] ref_bits;
        ref_bits = c_W2;
        for (int i = 0; i < 16; i++) q_flush.push_back('{bitv: ref_bits[15-i], done: (i == 15)});
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Output monitor sampling on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (n_rst) begin
            if (pend_chk) begin
                if (q_err.size() == 0) chk_eq("err_queue_empty", 32'd1, 32'd0);
                else chk_eq("crc_err", {31'd0, crc_err}, {31'd0, q_err.pop_front()});
            end
            pend_chk = check && !clear;
            if (crc_out_valid) begin
                if (clear) begin
                    chk_eq("abort_done", {31'd0, crc_done}, 32'd0);
                end else if (q_flush.size() == 0) begin
                    chk_eq("flush_queue_empty", 32'd1, 32'd0);
                end else begin
                    chk_eq("flush_bit", {31'd0, crc_out_bit}, {31'd0, q_flush[0].bitv});
                    if (shift_enable) begin
                        chk_eq("flush_done", {31'd0, crc_done}, {31'd0, q_flush[0].done});
                        void'(q_flush.pop_front());
                    end else begin
                        chk_eq("stall_done", {31'd0, crc_done}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] w1_bad;
        n_rst = 1'b0; clear = 1'b0; shift_enable = 1'b0;
        d_orig = 1'b0; flush_start = 1'b0; check = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
        chk_eq("rst_valid", {31'd0, crc_out_valid}, 32'd0);
        chk_eq("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk_eq("rst_crc_err", {31'd0, crc_err}, 32'd0);

        n_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("idle_crc_ok", {31'd0, crc_ok}, 32'd0);
        chk_eq("idle_valid", {31'd0, crc_out_valid}, 32'd0);
        chk_eq("idle_err_cnt", {24'd0, err_cnt}, 32'd0);

        // Good packet: data plus transmitted CRC leaves the residual.
        feed16(c_W0); feed16(c_W1); feed16(c_W2);
        chk_eq("good_crc_ok", {31'd0, crc_ok}, 32'd1);
        do_check(1'b0);

        // Flush of the data CRC; d_orig and a repeated flush_start must be ignored.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        feed16(c_W0); feed16(c_W1);
        start_flush();
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, (i == 5), 1'b0, 1'b0);
        chk_eq("flush_end_valid", {31'd0, crc_out_valid}, 32'd0);
        chk_eq("flush_queue_drained", q_flush.size(), 32'd0);
        feed16(c_W0); feed16(c_W1); feed16(c_W2);
        chk_eq("reload_crc_ok", {31'd0, crc_ok}, 32'd1);

        // Corrupted packet checked twice.
        w1_bad = c_W1 ^ 16'h0100;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        feed16(c_W0); feed16(w1_bad); feed16(c_W2);
        chk_eq("bad_crc_ok", {31'd0, crc_ok}, 32'd0);
        do_check(1'b1);
        do_check(1'b1);
        chk_eq("err_cnt_two", {24'd0, err_cnt}, {24'd0, c_CNT2});
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("err_hold", {31'd0, crc_err}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_eq("err_cleared", {31'd0, crc_err}, 32'd0);
        chk_eq("err_cnt_after_clear", {24'd0, err_cnt}, {24'd0, c_CNT2});

        // Stalled flush aborted by clear.
        feed16(c_W0); feed16(c_W1);
        start_flush();
        for (int k = 0; k < 24; k++) drive((k % 3) == 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("stall_shift_count", q_flush.size(), 32'd8);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_eq("abort_valid", {31'd0, crc_out_valid}, 32'd0);
        q_flush.delete();
        feed16(c_W0); feed16(c_W1); feed16(c_W2);
        chk_eq("abort_crc_ok", {31'd0, crc_ok}, 32'd1);

        // Asynchronous reset in the middle of a flush.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        feed16(c_W0); feed16(c_W1);
        start_flush();
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        shift_enable = 1'b0;
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk_eq("arst_valid", {31'd0, crc_out_valid}, 32'd0);
        chk_eq("arst_bit", {31'd0, crc_out_bit}, 32'd0);
        chk_eq("arst_done", {31'd0, crc_done}, 32'd0);
        chk_eq("arst_crc_err", {31'd0, crc_err}, 32'd0);
        chk_eq("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk_eq("arst_crc_ok", {31'd0, crc_ok}, 32'd0);
        q_flush.delete();
        pend_chk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("post_arst_valid", {31'd0, crc_out_valid}, 32'd0);
        chk_eq("err_queue_drained", q_err.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/usb_crc_engine.md
USB_CRC_ENGINE -- requirements
Module: usb_crc_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 16, meaning CRC width; only 5 and 16 are legal.
REQ-002 SHALL have parameter POLY, default 16'h8005, meaning generator polynomial without the implicit x^CRC_W term.
REQ-003 SHALL have parameter RESIDUAL, default 16'h800D, meaning the good-packet remainder; 5'h0C when CRC_W=5.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is posedge.
REQ-005 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port clear, input, 1 bit: synchronous reinitialise.
REQ-007 SHALL have port shift_enable, input, 1 bit: bit-time strobe.
REQ-008 SHALL have port d_orig, input, 1 bit: serial data bit, taken in arrival order.
REQ-009 SHALL have port flush_start, input, 1 bit: single-cycle request to shift out the CRC.
REQ-010 SHALL have port check, input, 1 bit: single-cycle end-of-packet check strobe.
REQ-011 SHALL have port crc_ok, output, 1 bit: high when register equals RESIDUAL.
REQ-012 SHALL have port crc_out_bit, output, 1 bit: transmit CRC bit.
REQ-013 SHALL have port crc_out_valid, output, 1 bit: high when crc_out_bit is meaningful.
REQ-014 SHALL have port crc_done, output, 1 bit: one-cycle pulse on the last flush shift.
REQ-015 SHALL have port crc_err, output, 1 bit: registered check result.
REQ-016 SHALL have port err_cnt, output, 8 bits: saturating count of failed checks.

Function
REQ-017 SHALL implement states ACCUM and FLUSH.
REQ-018 In ACCUM with shift_enable=1, SHALL compute fb = crc[W-1]^d_orig, then crc <= {crc[W-2:0],1'b0} ^ (fb ? POLY : 0).
REQ-019 In ACCUM with shift_enable=0, SHALL hold crc unchanged.
REQ-020 SHALL drive crc_ok combinationally as (crc == RESIDUAL).
REQ-021 flush_start in ACCUM SHALL enter FLUSH next cycle with bit counter = 0 and crc held.
REQ-022 In FLUSH, crc_out_valid=1 and crc_out_bit = ~crc[W-1].
REQ-023 In FLUSH with shift_enable=1, SHALL shift crc left with zero fill, ignore d_orig, and increment the counter.
REQ-024 On the CRC_W-th flush shift, SHALL pulse crc_done, reload crc with all-ones, and return to ACCUM.
REQ-025 flush_start while in FLUSH SHALL be ignored.
REQ-026 check SHALL register crc_err <= ~crc_ok one cycle later; crc_err holds until the next check, clear, or reset.
REQ-027 clear SHALL have priority over shift_enable, flush_start, and check: crc all-ones, state ACCUM, crc_err 0, err_cnt unchanged.
REQ-028 clear during FLUSH SHALL abort with no crc_done pulse.

Reset
REQ-029 n_rst=0 SHALL immediately force crc to all-ones, state ACCUM, counter 0, and crc_err, crc_done, crc_out_valid, crc_out_bit and err_cnt to 0; crc_ok follows the register (0).

Configuration
REQ-030 With USB_CRC_ERRCNT_EN defined, each check with crc_ok=0 SHALL increment err_cnt, saturating at 8'hFF; only n_rst clears it.
REQ-031 Without USB_CRC_ERRCNT_EN, err_cnt SHALL be constant 0 and no counter flops SHALL be synthesised.

Structure
REQ-032 Package usb_crc_pkg SHALL hold POLY16=16'h8005, POLY5=5'h05, RESIDUAL16=16'h800D, RESIDUAL5=5'h0C and the state enum.
REQ-033 Sub-module usb_crc_lfsr SHALL contain the parametrised register and next-state logic; usb_crc_engine holds the FSM, counter and check logic.

Verification
REQ-034 Reset, then clear idle -> crc all-ones, crc_ok=0, crc_out_valid=0, err_cnt=0.
REQ-035 CRC_W=16: feed 0000000010000000, 0100000011000000, 1111011101011110 MSB-first with shift_enable=1, then check -> crc_ok=1, crc_err=0.
REQ-036 CRC_W=16: feed the first 32 bits of REQ-035, then flush_start -> crc_out_bit sequence 1111011101011110, crc_done on the 16th shift, then crc all-ones.
REQ-037 Repeat REQ-035 with one data bit flipped, check twice -> crc_err=1, and err_cnt=2 with the macro, 0 without.
REQ-038 Toggle shift_enable 1-in-3 during a flush, then assert clear mid-flush -> stalled bits hold; abort with no crc_done; state ACCUM.
REQ-039 Assert n_rst=0 asynchronously mid-FLUSH -> all outputs reset before the next clk edge.
